// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON 32/64 round scheduler.
// simon_f is the SIMON mixing function at the default word width.
package simon_pkg;

    localparam int WORD_W = 16;
    localparam int ROUNDS = 32;

    typedef struct packed {
        logic [WORD_W-1:0] x;
        logic [WORD_W-1:0] y;
    } block_t;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] w);
        return ({w[WORD_W-2:0], w[WORD_W-1]} & {w[WORD_W-9:0], w[WORD_W-1:WORD_W-8]})
             ^ {w[WORD_W-3:0], w[WORD_W-1:WORD_W-2]};
    endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational SIMON round: (x, y, k) -> (y ^ f(x) ^ k, x).
// Width-generic so the same round can back key-schedule or reference models.
module simon_round
    import simon_pkg::*;
#(
    parameter int WORD_W = simon_pkg::WORD_W
) (
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic [WORD_W-1:0] key,
    output logic [WORD_W-1:0] x_nxt,
    output logic [WORD_W-1:0] y_nxt
);

    function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

    logic [WORD_W-1:0] f_x;

    assign f_x   = (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    assign x_nxt = y ^ f_x ^ key;
    assign y_nxt = x;

endmodule

// File: rtl/simon_round_scheduler.sv
// Time-shares one SIMON round datapath among N_REQ requesters with round-robin
// arbitration; each round waits on its key from the key-schedule block.
module simon_round_scheduler
    import simon_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ROUNDS = simon_pkg::ROUNDS,
    parameter int WORD_W = simon_pkg::WORD_W,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0]               req_dir,
    input  logic [N_REQ-1:0][2*WORD_W-1:0] req_data,
    input  logic [ROUNDS-1:0]              key_ready,
    input  logic [WORD_W-1:0]              round_key,
    output logic [IDX_W-1:0]               key_idx,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [2*WORD_W-1:0]            rsp_data,
    output logic                           busy
);

    sched_state_e       state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt, cur_id, grant_id;
    logic [IDX_W-1:0]   round_cnt;
    logic [WORD_W-1:0]  x_q, y_q, x_rnd, y_rnd;
    logic [2*WORD_W-1:0] grant_blk;
    dir_e               dir_q, grant_dir;
    logic [N_REQ-1:0]   grant_oh;
    logic               grant_any, accept, key_ok, last_round, step;

    // Rotate the valid vector so bit 0 is rr_ptr, take the first set bit,
    // then map the offset back to a requester index.
    always_comb begin
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        int                 g;
        dbl       = {req_valid, req_valid} >> rr_ptr;
        rot       = dbl[N_REQ-1:0];
        g         = 0;
        grant_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && rot[i]) begin
                grant_any = 1'b1;
                g         = int'(rr_ptr) + i;
            end
        end
        if (g >= N_REQ) g = g - N_REQ;
        grant_id = ID_W'(g);
        grant_oh = grant_any ? (N_REQ'(1) << grant_id) : '0;
    end

    always_comb begin
        rr_ptr_nxt = grant_id + 1'b1;
        if (int'(grant_id) == N_REQ - 1) rr_ptr_nxt = '0;
    end

    assign req_ready = (state == IDLE && !flush) ? grant_oh : '0;
    assign accept    = |req_ready;
    assign grant_blk = req_data[grant_id];
    assign grant_dir = dir_e'(req_dir[grant_id]);

    // Decrypt walks the key schedule backwards.
    always_comb begin
        key_idx = round_cnt;
        if (state == RUN && dir_q == DEC) key_idx = IDX_W'(ROUNDS - 1) - round_cnt;
    end

    assign key_ok     = key_ready[key_idx];
    assign last_round = (round_cnt == IDX_W'(ROUNDS - 1));
    assign step       = (state == RUN) && key_ok && !flush;

    simon_round #(
        .WORD_W (WORD_W)
    ) u_round (
        .x     (x_q),
        .y     (y_q),
        .key   (round_key),
        .x_nxt (x_rnd),
        .y_nxt (y_rnd)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (flush)                   state_nxt = IDLE;
                else if (key_ok && last_round) state_nxt = RESP;
            end
            RESP: if (flush || rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            round_cnt <= '0;
            x_q       <= '0;
            y_q       <= '0;
            dir_q     <= ENC;
            cur_id    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rr_ptr <= rr_ptr_nxt;
                cur_id <= grant_id;
                dir_q  <= grant_dir;
                // Decrypt runs the forward round on the swapped block.
                if (grant_dir == DEC) begin
                    x_q <= grant_blk[WORD_W-1:0];
                    y_q <= grant_blk[2*WORD_W-1:WORD_W];
                end else begin
                    x_q <= grant_blk[2*WORD_W-1:WORD_W];
                    y_q <= grant_blk[WORD_W-1:0];
                end
            end
            if (flush) begin
                round_cnt <= '0;
            end else if (step) begin
                round_cnt <= last_round ? '0 : round_cnt + 1'b1;
                x_q       <= x_rnd;
                y_q       <= y_rnd;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_id    = rsp_valid ? cur_id : '0;

    always_comb begin
        rsp_data = '0;
        if (rsp_valid) rsp_data = (dir_q == ENC) ? {x_q, y_q} : {y_q, x_q};
    end

endmodule

// File: tb/tb_simon_round_scheduler.sv
// Bench for simon_round_scheduler: directed scenarios plus randomized traffic,
// checked against a transaction-level SIMON 32/64 model and round-robin model.
module tb_simon_round_scheduler;

    logic             clk, rst_n, flush;
    logic [1:0]       req_valid, req_ready, req_dir;
    logic [1:0][31:0] req_data;
    logic [31:0]      key_ready;
    logic [15:0]      round_key;
    logic [4:0]       key_idx;
    logic             rsp_valid, rsp_ready;
    logic             rsp_id;
    logic [31:0]      rsp_data;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] ks [32];

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t sb [$];
    int   glog [$];
    int   gcyc [$];
    int   rr_m = 0;

    simon_round_scheduler #(.N_REQ(2), .ROUNDS(32), .WORD_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dir   (req_dir),
        .req_data  (req_data),
        .key_ready (key_ready),
        .round_key (round_key),
        .key_idx   (key_idx),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    assign round_key = ks[key_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rol(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int n);
        return rol(v, 16 - n);
    endfunction

    function automatic logic [15:0] ff(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    task automatic set_key(input logic [63:0] key);
        logic [15:0] k [32];
        logic [15:0] t;
        logic [63:0] z;
        z = 64'h19C3522FB386A45F;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t    = ror(k[i-1], 3) ^ k[i-3];
            t    = t ^ ror(t, 1);
            k[i] = ~k[i-4] ^ t ^ {15'b0, z[i-4]} ^ 16'd3;
        end
        for (int i = 0; i < 32; i++) ks[i] = k[i];
    endtask

    // Encrypt forward; decrypt with the explicit inverse round.
    function automatic logic [31:0] model(input logic d, input logic [31:0] blk);
        logic [15:0] x, y, t;
        x = blk[31:16];
        y = blk[15:0];
        if (!d) begin
            for (int i = 0; i < 32; i++) begin
                t = x; x = y ^ ff(x) ^ ks[i]; y = t;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                t = y; y = x ^ ff(y) ^ ks[i]; x = t;
            end
        end
        return {x, y};
    endfunction

    function automatic logic [1:0] arb(input logic [1:0] v, input int p);
        for (int k = 0; k < 2; k++) begin
            int j;
            j = (p + k) % 2;
            if (v[j]) return 2'b01 << j;
        end
        return 2'b00;
    endfunction

    // Per-cycle compare process.
    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic        hold_id;
    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        exp_t       e;
        if (!rst_n) begin
            sb.delete();
            rr_m   = 0;
            hold_v = 1'b0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_key_idx", key_idx, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("busy", busy, (sb.size() != 0));
            exp_rdy = (!busy && !flush) ? arb(req_valid, rr_m) : 2'b00;
            chk("req_ready", req_ready, exp_rdy);
            if (hold_v) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_data", rsp_data, hold_d);
                chk("hold_id", rsp_id, hold_id);
            end
            hold_v = 1'b0;
            if (flush) begin
                if (busy && sb.size() != 0) void'(sb.pop_front());
            end else begin
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        e = sb[0];
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_data", rsp_data, e.data);
                        if (rsp_ready) void'(sb.pop_front());
                        else begin
                            hold_v  = 1'b1;
                            hold_d  = rsp_data;
                            hold_id = rsp_id;
                        end
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        e.id   = i;
                        e.data = model(req_dir[i], req_data[i]);
                        sb.push_back(e);
                        rr_m = (i + 1) % 2;
                        glog.push_back(i);
                        gcyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic run_block(input int r, input logic d, input logic [31:0] blk,
                             input int st_idx, input int st_len, input int hold_len,
                             output int lat, output logic [31:0] got, output int gid,
                             output int stalled, output int held);
        int c;
        bit done;
        @(posedge clk); #1;
        req_valid    = 2'b00;
        req_valid[r] = 1'b1;
        req_dir[r]   = d;
        req_data[r]  = blk;
        rsp_ready    = (hold_len == 0);
        key_ready    = '1;
        if (st_idx >= 0) key_ready[st_idx] = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end while (!req_ready[r] && c < 20);
        chk("grant", req_ready[r], 1);
        @(posedge clk); #1;
        // Keep every requester pushing and scramble their data while busy.
        req_valid   = 2'b11;
        req_dir     = 2'($urandom());
        req_data[0] = $urandom();
        req_data[1] = $urandom();
        c = 0; done = 0; lat = 0; got = '0; gid = -1; stalled = 0; held = 0;
        while (!done && c < 200) begin
            @(negedge clk); c++;
            if (rsp_valid) begin
                if (lat == 0) begin lat = c; got = rsp_data; gid = int'(rsp_id); end
                if (rsp_ready) done = 1; else held++;
            end else if (lat == 0) begin
                chk("key_idx", key_idx, d ? 31 - (c - 1 - stalled) : c - 1 - stalled);
                if (st_idx >= 0 && !key_ready[st_idx] && int'(key_idx) == st_idx) stalled++;
            end
            @(posedge clk); #1;
            if (done) req_valid = 2'b00;
            if (st_idx >= 0 && stalled >= st_len) key_ready[st_idx] = 1'b1;
            if (held >= hold_len) rsp_ready = 1'b1;
        end
        chk("rsp_timeout", done, 1);
        req_valid = 2'b00;
        key_ready = '1;
        rsp_ready = 1'b1;
    endtask

    initial begin
        int lat, gid, stl, hld, c, nrsp;
        logic [31:0] got;
        rst_n = 1'b1; flush = 1'b0; req_valid = '0; req_dir = '0; req_data = '0;
        key_ready = '1; rsp_ready = 1'b1;
        set_key(64'h1918_1110_0908_0100);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("model_enc", model(1'b0, 32'h6565_6877), 32'hc69b_e9bb);
        chk("model_dec", model(1'b1, 32'hc69b_e9bb), 32'h6565_6877);

        @(negedge clk);
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_key_idx", key_idx, 0);

        // Encrypt on req0.
        run_block(0, 1'b0, 32'h6565_6877, -1, 0, 0, lat, got, gid, stl, hld);
        chk("t1_latency", lat, 33);
        chk("t1_data", got, 32'hc69b_e9bb);
        chk("t1_id", gid, 0);

        // Decrypt on req1; key_idx checked 31..0 inside run_block.
        run_block(1, 1'b1, 32'hc69b_e9bb, -1, 0, 0, lat, got, gid, stl, hld);
        chk("t2_latency", lat, 33);
        chk("t2_data", got, 32'h6565_6877);
        chk("t2_id", gid, 1);

        // Key 5 withheld for 10 cycles.
        run_block(0, 1'b0, 32'h6565_6877, 5, 10, 0, lat, got, gid, stl, hld);
        chk("t4_stalls", stl, 10);
        chk("t4_latency", lat, 43);
        chk("t4_data", got, 32'hc69b_e9bb);

        // Consumer back-pressure for 7 cycles.
        run_block(1, 1'b0, 32'h6565_6877, -1, 0, 7, lat, got, gid, stl, hld);
        chk("t5_held", hld, 7);
        chk("t5_latency", lat, 33);
        chk("t5_data", got, 32'hc69b_e9bb);
        chk("t5_id", gid, 1);

        // Both requesters continuously valid.
        @(posedge clk); #1;
        glog.delete(); gcyc.delete();
        req_valid = 2'b11; req_dir = 2'b00;
        req_data[0] = 32'h6565_6877; req_data[1] = $urandom();
        c = 0;
        while (glog.size() < 4 && c < 400) begin
            @(negedge clk); c++;
            if (glog.size() < 4) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        c = 0;
        do begin @(negedge clk); c++; end while ((busy || sb.size() != 0) && c < 100);
        chk("t3_grants", glog.size(), 4);
        if (glog.size() >= 4) begin
            chk("t3_g0", glog[0], 0);
            chk("t3_g1", glog[1], 1);
            chk("t3_g2", glog[2], 0);
            chk("t3_g3", glog[3], 1);
            chk("t3_period", gcyc[1] - gcyc[0], 34);
            chk("t3_period2", gcyc[3] - gcyc[2], 34);
        end

        // Flush at round 12.
        @(posedge clk); #1;
        req_valid = 2'b01; req_dir = 2'b00; req_data[0] = 32'h6565_6877;
        c = 0;
        do begin @(negedge clk); c++; end while (!req_ready[0] && c < 20);
        @(posedge clk); #1;
        req_valid = 2'b00;
        c = 0;
        do begin @(negedge clk); c++; end while (key_idx != 5'd11 && c < 50);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("t6_flush_round", key_idx, 12);
        @(posedge clk); #1 flush = 1'b0;
        nrsp = 0;
        repeat (40) begin @(negedge clk); if (rsp_valid) nrsp++; end
        chk("t6_flush_no_rsp", nrsp, 0);
        chk("t6_flush_idle", busy, 0);

        // Pointer kept across flush: next grant goes to req1.
        @(posedge clk); #1;
        req_valid = 2'b11; req_dir = 2'b00; req_data[1] = $urandom();
        @(negedge clk);
        chk("t6_rr_after_flush", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        c = 0;
        do begin @(negedge clk); c++; end while (key_idx != 5'd19 && c < 50);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_key_idx", key_idx, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        nrsp = 0;
        repeat (40) begin @(negedge clk); if (rsp_valid) nrsp++; end
        chk("t6_rst_no_rsp", nrsp, 0);
        run_block(0, 1'b0, 32'h6565_6877, -1, 0, 0, lat, got, gid, stl, hld);
        chk("t6_after_latency", lat, 33);
        chk("t6_after_data", got, 32'hc69b_e9bb);

        // Randomized traffic under a fresh key.
        @(posedge clk); #1;
        set_key({$urandom(), $urandom()});
        repeat (3000) begin
            @(posedge clk); #1;
            req_valid   = 2'($urandom());
            req_dir     = 2'($urandom());
            req_data[0] = $urandom();
            req_data[1] = $urandom();
            for (int i = 0; i < 32; i++) key_ready[i] = ($urandom_range(0, 7) != 0);
            rsp_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #1;
        req_valid = 2'b00; flush = 1'b0; key_ready = '1; rsp_ready = 1'b1;
        c = 0;
        do begin @(negedge clk); c++; end while ((busy || sb.size() != 0) && c < 100);
        chk("drain_sb", sb.size(), 0);
        chk("drain_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
